vga_display_top: RTL and testbench
==================================

Name: vga_display_top

Overview:
- Top-level VGA test-pattern generator for bring-up of the video path.
- Divides the 100 MHz system clock to a 25 MHz pixel rate.
- Produces standard 640x480@60 Hz timing with active-low h_sync and v_sync.
- Drives 12-bit RGB with a pattern selected by 3 slide switches; also mirrors reset onto an LED.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- CLK_DIV, 4, system clocks per pixel

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  reset; one clock, synchronous, active-high
- sw  in  3  pattern select
- h_sync  out  1  horizontal sync, active low
- v_sync  out  1  vertical sync, active low
- rgb  out  12  pixel colour {R[3:0], G[3:0], B[3:0]}
- led_rst  out  1  reset indicator LED

Behaviour:
- Pixel enable
  - 2-bit divider counts 0..3 on every clk.
  - pix_en is high for one clk when the divider = 3, i.e. one pulse every 4 clk.
  - All video state advances only on clk edges where pix_en = 1.
- Horizontal counter h_cnt (0..799)
  - Increments on each pix_en and wraps to 0 after 799.
- Vertical counter v_cnt (0..524)
  - Increments when h_cnt wraps, and itself wraps to 0 after 524.
- Sync and video windows
  - h_sync is low for h_cnt 656..751 inclusive.
  - v_sync is low for v_cnt 490..491 inclusive.
  - Active video is h_cnt < 640 and v_cnt < 480.
- Output registration
  - h_sync, v_sync and rgb are registered from the pre-increment counter values on the same pix_en edge.
  - All three outputs therefore carry an identical one-pixel pipeline delay and stay aligned with each other.
- Blanking: rgb = 12'h000 whenever outside active video.
- Switch handling
  - sw passes through a 2-flop synchronizer on clk.
  - The synchronized value is latched into pat_sel only on the pix_en edge where h_cnt = 0 and v_cnt = 0.
  - Pattern changes therefore take effect only at frame start (no tearing).
- Patterns, indexed by pat_sel:
  - 0: solid black 000
  - 1: solid white FFF
  - 2: 8 vertical bars of 80 px each; left to right FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000
  - 3: 8 horizontal bars of 60 lines each, same colour order top to bottom
  - 4: 32x32 checkerboard; FFF when h_cnt[5] XOR v_cnt[5] = 0, else 000
  - 5: solid red F00
  - 6: solid green 0F0
  - 7: solid blue 00F
- led_rst: combinational copy of rst.
- Reset (synchronous, while rst = 1)
  - Divider, h_cnt, v_cnt and pat_sel clear to 0; synchronizer flops clear to 0.
  - h_sync = 1, v_sync = 1, rgb = 000.
  - Reset asserted mid-frame aborts the frame immediately.
  - After rst deasserts, the first pix_en occurs on the 4th clk, and the first frame starts at h_cnt = 0, v_cnt = 0.
- Timing figures
  - Line = 800 px = 3200 clk = 32.0 us.
  - Frame = 525 lines = 1,680,000 clk = 16.8 ms (59.52 Hz).

Test Plan:
- Reset hold: rst=1 for 10 clk -> h_sync=1, v_sync=1, rgb=000, led_rst=1 throughout; led_rst=0 immediately once rst=0.
- Horizontal timing: after reset release, measure h_sync -> falling edges every 3200 clk (32.0 us); low width 384 clk (3.84 us); first fall 656 px (2624 clk, ±4) after release.
- Vertical timing: run 2 frames -> v_sync falls every 1,680,000 clk; low width 2 lines = 6400 clk; edges coincide with h_sync-aligned pixel positions.
- Colour bars: sw=2 applied right after reset, observed in frame 1 -> line 0 shows FFF for px 0..79, FF0 for 80..159, … 000 for 560..639; rgb=000 for px 640..799 and lines 480..524.
- Frame-boundary latch: switch sw 2->5 mid-frame -> remainder of that frame keeps bars; next frame is all F00 in the visible area.
- Checkerboard and mid-frame reset: sw=4 -> px (0,0)=FFF, (32,0)=000, (32,32)=FFF. Assert rst during line 200 -> outputs return to reset values next clk, and timing restarts from h_cnt = 0, v_cnt = 0.

Source files
------------

// File: rtl/vga_display_top.sv
// 640x480@60 VGA test-pattern generator: clock divider, raster counters, sync and pattern logic.
// Latency: h_sync/v_sync/rgb lag the raster counters by exactly one pixel (one pix_en edge).
// Backpressure: none; the raster free-runs, and sw is sampled only at frame start.
module vga_display_top #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sw,
    output logic        h_sync,
    output logic        v_sync,
    output logic [11:0] rgb,
    output logic        led_rst
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_VISIBLE + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = $clog2(CLK_DIV);
    localparam int BAR_W    = H_VISIBLE / 8;
    localparam int BAR_H    = V_VISIBLE / 8;

    logic [DW-1:0] div;
    logic          pix_en;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [2:0]    sw_meta;
    logic [2:0]    sw_sync;
    logic [2:0]    pat_sel;
    logic [2:0]    sel_now;
    logic          frame_start;
    logic          active;
    logic [2:0]    h_bar;
    logic [2:0]    v_bar;
    logic [11:0]   pat_rgb;

    // Shared colour order for both bar patterns, index 0 at left/top.
    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 12'hFFF;
            3'd1:    bar_colour = 12'hFF0;
            3'd2:    bar_colour = 12'h0FF;
            3'd3:    bar_colour = 12'h0F0;
            3'd4:    bar_colour = 12'hF0F;
            3'd5:    bar_colour = 12'hF00;
            3'd6:    bar_colour = 12'h00F;
            default: bar_colour = 12'h000;
        endcase
    endfunction

    assign pix_en      = (int'(div) == CLK_DIV - 1);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);
    assign active      = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);
    // The frame's first pixel already uses the newly latched selection.
    assign sel_now     = frame_start ? sw_sync : pat_sel;
    assign led_rst     = rst;

    // Pixel-rate divider: one pix_en pulse every CLK_DIV system clocks.
    always_ff @(posedge clk) begin
        if (rst)         div <= '0;
        else if (pix_en) div <= '0;
        else             div <= div + 1'b1;
    end

    // Raster counters: h wraps at line end and carries into v.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (int'(h_cnt) == H_TOTAL - 1) begin
                h_cnt <= '0;
                if (int'(v_cnt) == V_TOTAL - 1) v_cnt <= '0;
                else                            v_cnt <= v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous slide switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    // Pattern colour for the current (pre-increment) raster position.
    always_comb begin
        h_bar   = '0;
        v_bar   = '0;
        pat_rgb = 12'h000;
        for (int i = 1; i < 8; i++) begin
            if (int'(h_cnt) >= i * BAR_W) h_bar = 3'(i);
            if (int'(v_cnt) >= i * BAR_H) v_bar = 3'(i);
        end
        case (sel_now)
            3'd0: pat_rgb = 12'h000;
            3'd1: pat_rgb = 12'hFFF;
            3'd2: pat_rgb = bar_colour(h_bar);
            3'd3: pat_rgb = bar_colour(v_bar);
            3'd4: pat_rgb = (h_cnt[5] ^ v_cnt[5]) ? 12'h000 : 12'hFFF;
            3'd5: pat_rgb = 12'hF00;
            3'd6: pat_rgb = 12'h0F0;
            3'd7: pat_rgb = 12'h00F;
            default: pat_rgb = 12'h000;
        endcase
    end

    // Output registers and frame-start pattern latch, all on the same pix_en edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_sync  <= 1'b1;
            v_sync  <= 1'b1;
            rgb     <= 12'h000;
            pat_sel <= '0;
        end else if (pix_en) begin
            h_sync <= !((int'(h_cnt) >= HS_FIRST) && (int'(h_cnt) <= HS_LAST));
            v_sync <= !((int'(v_cnt) >= VS_FIRST) && (int'(v_cnt) <= VS_LAST));
            rgb    <= active ? pat_rgb : 12'h000;
            if (frame_start) pat_sel <= sw_sync;
        end
    end

endmodule

// File: tb/tb_vga_display_top.sv
// Bench for vga_display_top: full-size raster plus a shrunken raster that reaches frame edges quickly.
// Latency: expectations are indexed by clock count after reset release (pixel p visible from edge 4+4p).
// Backpressure: none; a negedge monitor pops time-ordered expectations from a scoreboard queue.
module tb_vga_display_top;

    localparam int K_RGB = 0;
    localparam int K_HS  = 1;
    localparam int K_VS  = 2;
    localparam int K_LED = 3;
    localparam int B0    = 10;          // first reset release
    localparam int RST2  = B0 + 25700;  // mid-frame reset assertion
    localparam int B1    = RST2 + 3;    // second reset release

    typedef struct {
        int          at;
        int          unit;
        int          kind;
        logic [11:0] exp;
        string       name;
    } probe_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sw  = 3'd2;
    logic        hs_b, vs_b, led_b, hs_s, vs_s, led_s;
    logic [11:0] rgb_b, rgb_s;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    probe_t      sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    vga_display_top dut_big (
        .clk(clk), .rst(rst), .sw(sw),
        .h_sync(hs_b), .v_sync(vs_b), .rgb(rgb_b), .led_rst(led_b)
    );

    // 72 px x 44 line raster: sync low at h 66..69 and v 41..42, bars 8 px wide.
    vga_display_top #(
        .H_VISIBLE(64), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(40), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(4)
    ) dut_small (
        .clk(clk), .rst(rst), .sw(sw),
        .h_sync(hs_s), .v_sync(vs_s), .rgb(rgb_s), .led_rst(led_s)
    );

    // Negedge cycle (relative to release) at which pixel (h,v) of a frame is held, one after its edge.
    function automatic int pe(input int unit, input int h, input int v, input int frame);
        int ht, vt;
        ht = (unit != 0) ? 72 : 800;
        vt = (unit != 0) ? 44 : 525;
        return 4 + 4 * ((frame * vt + v) * ht + h) + 1;
    endfunction

    task automatic probe(input int unit, input string name, input int kind, input int at,
                         input logic [11:0] exp);
        probe_t p;
        int     idx;
        p.at = at; p.unit = unit; p.kind = kind; p.exp = exp; p.name = name;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, p);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    // Monitor: compares every expectation whose cycle has come up.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            probe_t      p;
            logic [11:0] got;
            p = sb.pop_front();
            case (p.kind)
                K_RGB:   got = (p.unit != 0) ? rgb_s : rgb_b;
                K_HS:    got = {11'd0, (p.unit != 0) ? hs_s : hs_b};
                K_VS:    got = {11'd0, (p.unit != 0) ? vs_s : vs_b};
                default: got = {11'd0, (p.unit != 0) ? led_s : led_b};
            endcase
            total++;
            if (p.at < cyc) begin
                bad++;
                $display("FAIL %s: sample missed at cycle %0d, required cycle %0d", p.name, cyc, p.at);
            end else if (got !== p.exp) begin
                bad++;
                $display("FAIL %s: unit %0d cycle %0d got %h expected %h", p.name, p.unit, cyc, got, p.exp);
            end
        end
    end

    initial begin
        // Reset hold.
        probe(0, "rst_hs",      K_HS,  3, 12'h1);
        probe(0, "rst_vs",      K_VS,  3, 12'h1);
        probe(0, "rst_rgb",     K_RGB, 3, 12'h000);
        probe(0, "rst_led",     K_LED, 3, 12'h1);
        probe(1, "rst_rgb_s",   K_RGB, 10, 12'h000);
        probe(0, "rst_led_end", K_LED, 10, 12'h1);
        probe(0, "led_release", K_LED, B0 + 1, 12'h0);
        probe(0, "pre_pix_en",  K_RGB, B0 + 3, 12'h000);
        probe(0, "first_pix",   K_RGB, B0 + 4, 12'hFFF);
        // Full-size colour bars on line 0, including the blank region.
        probe(0, "bar_px0",   K_RGB, B0 + pe(0, 0, 0, 0),   12'hFFF);
        probe(0, "bar_px79",  K_RGB, B0 + pe(0, 79, 0, 0),  12'hFFF);
        probe(0, "bar_px80",  K_RGB, B0 + pe(0, 80, 0, 0),  12'hFF0);
        probe(0, "bar_px160", K_RGB, B0 + pe(0, 160, 0, 0), 12'h0FF);
        probe(0, "bar_px240", K_RGB, B0 + pe(0, 240, 0, 0), 12'h0F0);
        probe(0, "bar_px320", K_RGB, B0 + pe(0, 320, 0, 0), 12'hF0F);
        probe(0, "bar_px400", K_RGB, B0 + pe(0, 400, 0, 0), 12'hF00);
        probe(0, "bar_px480", K_RGB, B0 + pe(0, 480, 0, 0), 12'h00F);
        probe(0, "bar_px559", K_RGB, B0 + pe(0, 559, 0, 0), 12'h00F);
        probe(0, "bar_px560", K_RGB, B0 + pe(0, 560, 0, 0), 12'h000);
        probe(0, "blank_px700", K_RGB, B0 + pe(0, 700, 0, 0), 12'h000);
        // Full-size horizontal sync window and line period.
        probe(0, "hs_px655",    K_HS, B0 + pe(0, 655, 0, 0), 12'h1);
        probe(0, "hs_px656",    K_HS, B0 + pe(0, 656, 0, 0), 12'h0);
        probe(0, "hs_px751",    K_HS, B0 + pe(0, 751, 0, 0), 12'h0);
        probe(0, "hs_px752",    K_HS, B0 + pe(0, 752, 0, 0), 12'h1);
        probe(0, "vs_line0",    K_VS, B0 + pe(0, 656, 0, 0), 12'h1);
        probe(0, "hs_l1_px655", K_HS, B0 + pe(0, 655, 1, 0), 12'h1);
        probe(0, "hs_l1_px656", K_HS, B0 + pe(0, 656, 1, 0), 12'h0);
        // sw 2->5 at B0+2000: full-size frame keeps bars.
        probe(0, "keep_l1_px100", K_RGB, B0 + pe(0, 100, 1, 0), 12'hFF0);
        probe(0, "keep_l3_px500", K_RGB, B0 + pe(0, 500, 3, 0), 12'h00F);
        // Small raster frame 0: bars, sync windows, vertical frame timing.
        probe(1, "s_bar_px0",  K_RGB, B0 + pe(1, 0, 0, 0),  12'hFFF);
        probe(1, "s_bar_px8",  K_RGB, B0 + pe(1, 8, 0, 0),  12'hFF0);
        probe(1, "s_bar_px55", K_RGB, B0 + pe(1, 55, 0, 0), 12'h00F);
        probe(1, "s_hs_65",    K_HS,  B0 + pe(1, 65, 0, 0), 12'h1);
        probe(1, "s_hs_66",    K_HS,  B0 + pe(1, 66, 0, 0), 12'h0);
        probe(1, "s_hs_69",    K_HS,  B0 + pe(1, 69, 0, 0), 12'h0);
        probe(1, "s_hs_70",    K_HS,  B0 + pe(1, 70, 0, 0), 12'h1);
        probe(1, "s_keep_8_20", K_RGB, B0 + pe(1, 8, 20, 0), 12'hFF0);
        probe(1, "s_vs_l40",   K_VS,  B0 + pe(1, 0, 40, 0),  12'h1);
        probe(1, "s_vs_l41",   K_VS,  B0 + pe(1, 0, 41, 0),  12'h0);
        probe(1, "s_vs_l42",   K_VS,  B0 + pe(1, 71, 42, 0), 12'h0);
        probe(1, "s_vs_l43",   K_VS,  B0 + pe(1, 0, 43, 0),  12'h1);
        // Small raster frame 1: sw=5 latched at frame start; sw=4 at B0+20000 must wait.
        probe(1, "s_f1_red_8_0",   K_RGB, B0 + pe(1, 8, 0, 1),   12'hF00);
        probe(1, "s_f1_blank_h64", K_RGB, B0 + pe(1, 64, 0, 1),  12'h000);
        probe(1, "s_f1_red_63_20", K_RGB, B0 + pe(1, 63, 20, 1), 12'hF00);
        probe(1, "s_f1_keep_10_33", K_RGB, B0 + pe(1, 10, 33, 1), 12'hF00);
        probe(1, "s_f1_blank_v40", K_RGB, B0 + pe(1, 0, 40, 1),  12'h000);
        probe(1, "s_f1_vs_l41",    K_VS,  B0 + pe(1, 0, 41, 1),  12'h0);
        // Small raster frame 2: checkerboard latched at the frame boundary.
        probe(1, "s_f2_chk_0_0",  K_RGB, B0 + pe(1, 0, 0, 2),  12'hFFF);
        probe(1, "s_f2_chk_32_0", K_RGB, B0 + pe(1, 32, 0, 2), 12'h000);
        // Mid-frame reset: outputs drop to reset values on the first rst edge.
        probe(1, "s_pre_rst",     K_RGB, RST2 - 1, 12'hFFF);
        probe(0, "b_pre_rst",     K_RGB, RST2 - 1, 12'hFFF);
        probe(1, "s_rst_rgb",     K_RGB, RST2 + 1, 12'h000);
        probe(0, "b_rst_rgb",     K_RGB, RST2 + 1, 12'h000);
        probe(0, "b_rst_hs",      K_HS,  RST2 + 1, 12'h1);
        probe(0, "b_rst_vs",      K_VS,  RST2 + 1, 12'h1);
        probe(0, "b_rst_led",     K_LED, RST2 + 1, 12'h1);
        // After second release: restart from (0,0) with checkerboard.
        probe(0, "led_release2",  K_LED, B1 + 1, 12'h0);
        probe(1, "s_pre_pix_en2", K_RGB, B1 + 3, 12'h000);
        probe(1, "s_first_pix2",  K_RGB, B1 + 4, 12'hFFF);
        probe(1, "chk_31_0",  K_RGB, B1 + pe(1, 31, 0, 0),  12'hFFF);
        probe(1, "chk_32_0",  K_RGB, B1 + pe(1, 32, 0, 0),  12'h000);
        probe(1, "chk_0_32",  K_RGB, B1 + pe(1, 0, 32, 0),  12'h000);
        probe(1, "chk_32_32", K_RGB, B1 + pe(1, 32, 32, 0), 12'hFFF);
        probe(0, "b_chk_0_0",  K_RGB, B1 + pe(0, 0, 0, 0),  12'hFFF);
        probe(0, "b_chk_32_0", K_RGB, B1 + pe(0, 32, 0, 0), 12'h000);
        probe(0, "b_chk_64_0", K_RGB, B1 + pe(0, 64, 0, 0), 12'hFFF);
        probe(0, "b_hs2_655",  K_HS,  B1 + pe(0, 655, 0, 0), 12'h1);
        probe(0, "b_hs2_656",  K_HS,  B1 + pe(0, 656, 0, 0), 12'h0);

        // Stimulus schedule.
        wait_cyc(B0);
        rst = 1'b0;
        wait_cyc(B0 + 2000);
        sw = 3'd5;
        wait_cyc(B0 + 20000);
        sw = 3'd4;
        wait_cyc(RST2);
        rst = 1'b1;
        wait_cyc(B1);
        rst = 1'b0;
        wait_cyc(B1 + 9400);

        // Anything still queued was never reached by the monitor.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            probe_t p;
            p = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never sampled, required cycle %0d, run ended at %0d", p.name, p.at, cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
